ccu_snoop_fanout: RTL and testbench

Snoop fan-out/fan-in stage directly downstream of the CCU read-snoop controller. It takes one AC request plus a domain mask and broadcasts the AC to every selected snooping master. It then collects and merges their CR responses into a single upstream CR. Finally it forwards exactly one CD stream upstream and drains CD data from every other snooper that transfers data.

---
 rtl/ccu_snoop_fanout.sv | 209 ++++++++++++++++++++
 tb/tb_ccu_snoop_fanout.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_fanout.sv
// ccu_snoop_fanout: broadcasts one AC snoop to the selected masters, merges their CR
// responses into a single upstream CR, then forwards one CD stream and drains the rest.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new upstream AC
// SNOOP  | AC fanned out; collecting CR from every masked snooper
// RESP   | merged CR presented upstream
// DATA   | forwarding the selected CD stream, draining other DT snoopers
module ccu_snoop_fanout #(
  parameter int unsigned NumSnoopers = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned CdBeats     = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             ac_valid_i,
  output logic                             ac_ready_o,
  input  logic [AddrWidth-1:0]             ac_addr_i,
  input  logic [3:0]                       ac_snoop_i,
  input  logic [2:0]                       ac_prot_i,
  input  logic [NumSnoopers-1:0]           domain_mask_i,
  output logic                             cr_valid_o,
  input  logic                             cr_ready_i,
  output logic [4:0]                       cr_resp_o,
  output logic                             cd_valid_o,
  input  logic                             cd_ready_i,
  output logic [DataWidth-1:0]             cd_data_o,
  output logic                             cd_last_o,
  output logic [NumSnoopers-1:0]           snp_ac_valid_o,
  input  logic [NumSnoopers-1:0]           snp_ac_ready_i,
  output logic [AddrWidth-1:0]             snp_ac_addr_o,
  output logic [3:0]                       snp_ac_snoop_o,
  output logic [2:0]                       snp_ac_prot_o,
  input  logic [NumSnoopers-1:0]           snp_cr_valid_i,
  output logic [NumSnoopers-1:0]           snp_cr_ready_o,
  input  logic [5*NumSnoopers-1:0]         snp_cr_resp_i,
  input  logic [NumSnoopers-1:0]           snp_cd_valid_i,
  output logic [NumSnoopers-1:0]           snp_cd_ready_o,
  input  logic [DataWidth*NumSnoopers-1:0] snp_cd_data_i,
  input  logic [NumSnoopers-1:0]           snp_cd_last_i
);

  localparam int unsigned SelW  = (NumSnoopers > 1) ? $clog2(NumSnoopers) : 1;
  localparam int unsigned BeatW = $clog2(CdBeats + 1);

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_RESP, S_DATA} state_e;

  state_e                 r_state;
  logic [NumSnoopers-1:0] r_mask, r_ac_done, r_cr_done, r_cd_done, r_dt;
  logic [4:0]             r_cr_resp [NumSnoopers];
  logic [4:0]             r_merged;
  logic [SelW-1:0]        r_sel;
  logic [AddrWidth-1:0]   r_addr;
  logic [3:0]             r_snoop;
  logic [2:0]             r_prot;

  logic                   w_in_snoop, w_in_data;
  logic [NumSnoopers-1:0] w_ac_hs, w_cr_hs, w_cd_hs, w_cr_done_nxt, w_cd_done_nxt;
  logic [4:0]             w_resp [NumSnoopers];
  logic [NumSnoopers-1:0] w_dt;
  logic                   w_shared, w_unique, w_f1, w_f2;
  logic [SelW-1:0]        w_i1, w_i2, w_i3, w_sel;
  logic [4:0]             w_merged;

  assign w_in_snoop = (r_state == S_SNOOP);
  assign w_in_data  = (r_state == S_DATA);

  assign ac_ready_o     = (r_state == S_IDLE);
  assign cr_valid_o     = (r_state == S_RESP);
  assign cr_resp_o      = (r_state == S_RESP) ? r_merged : '0;
  assign snp_ac_addr_o  = r_addr;
  assign snp_ac_snoop_o = r_snoop;
  assign snp_ac_prot_o  = r_prot;

  assign snp_ac_valid_o = w_in_snoop ? (r_mask & ~r_ac_done) : '0;
  assign snp_cr_ready_o = w_in_snoop ? (r_mask & ~r_cr_done) : '0;
  assign w_ac_hs        = snp_ac_valid_o & snp_ac_ready_i;
  assign w_cr_hs        = snp_cr_valid_i & snp_cr_ready_o;
  assign w_cr_done_nxt  = r_cr_done | w_cr_hs;

  // The selected stream stops forwarding once its last beat has gone through.
  assign cd_valid_o    = w_in_data & ~r_cd_done[r_sel] & snp_cd_valid_i[r_sel];
  assign cd_data_o     = w_in_data ? snp_cd_data_i[int'(r_sel)*DataWidth +: DataWidth] : '0;
  assign cd_last_o     = w_in_data & snp_cd_last_i[r_sel];
  assign w_cd_hs       = snp_cd_valid_i & snp_cd_ready_o;
  assign w_cd_done_nxt = r_cd_done | (w_cd_hs & snp_cd_last_i);

  // CD ready: selected snooper follows upstream ready, other DT snoopers are drained freely.
  always_comb begin
    snp_cd_ready_o = '0;
    if (w_in_data) begin
      for (int i = 0; i < int'(NumSnoopers); i++) begin
        if (r_dt[i] && !r_cd_done[i]) begin
          snp_cd_ready_o[i] = (SelW'(i) == r_sel) ? cd_ready_i : 1'b1;
        end
      end
    end
  end

  // CR merge over stored responses plus any accepted this cycle; descending scan leaves lowest index.
  always_comb begin
    w_dt     = '0;
    w_shared = 1'b0;
    w_unique = 1'b0;
    w_f1     = 1'b0;
    w_f2     = 1'b0;
    w_i1     = '0;
    w_i2     = '0;
    w_i3     = '0;
    for (int i = int'(NumSnoopers) - 1; i >= 0; i--) begin
      w_resp[i] = w_cr_hs[i] ? snp_cr_resp_i[5*i +: 5] : r_cr_resp[i];
      if (!r_mask[i]) w_resp[i] = '0;
      w_dt[i]   = w_resp[i][0];
      w_shared  = w_shared | w_resp[i][3];
      w_unique  = w_unique | w_resp[i][4];
      if (w_resp[i][0] && w_resp[i][2] && !w_resp[i][1]) begin
        w_f1 = 1'b1;
        w_i1 = SelW'(i);
      end
      if (w_resp[i][0] && !w_resp[i][1]) begin
        w_f2 = 1'b1;
        w_i2 = SelW'(i);
      end
      if (w_resp[i][0]) w_i3 = SelW'(i);
    end
    w_sel    = w_f1 ? w_i1 : (w_f2 ? w_i2 : w_i3);
    w_merged = {w_unique, w_shared,
                w_resp[w_sel][2] & (|w_dt), w_resp[w_sel][1] & (|w_dt), |w_dt};
  end

  // Transaction FSM: capture, CR collection, merged response, data phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_ac_done <= '0;
      r_cr_done <= '0;
      r_cd_done <= '0;
      r_dt      <= '0;
      r_merged  <= '0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_snoop   <= '0;
      r_prot    <= '0;
      for (int i = 0; i < int'(NumSnoopers); i++) r_cr_resp[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ac_valid_i) begin
            r_addr    <= ac_addr_i;
            r_snoop   <= ac_snoop_i;
            r_prot    <= ac_prot_i;
            r_mask    <= domain_mask_i;
            r_ac_done <= '0;
            r_cr_done <= '0;
            r_cd_done <= '0;
            r_dt      <= '0;
            r_merged  <= '0;
            r_sel     <= '0;
            for (int i = 0; i < int'(NumSnoopers); i++) r_cr_resp[i] <= '0;
            r_state   <= (|domain_mask_i) ? S_SNOOP : S_RESP;
          end
        end
        S_SNOOP: begin
          r_ac_done <= r_ac_done | w_ac_hs;
          r_cr_done <= w_cr_done_nxt;
          for (int i = 0; i < int'(NumSnoopers); i++) begin
            if (w_cr_hs[i]) r_cr_resp[i] <= snp_cr_resp_i[5*i +: 5];
          end
          if (w_cr_done_nxt == r_mask) begin
            r_merged <= w_merged;
            r_sel    <= w_sel;
            r_dt     <= w_dt;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (cr_ready_i) r_state <= r_merged[0] ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          r_cd_done <= w_cd_done_nxt;
          if ((w_cd_done_nxt & r_dt) == r_dt) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < NumSnoopers; g++) begin : g_beat_chk
    logic [BeatW-1:0] r_beat;

    // Per-snooper beat count, used only to check where the last beat lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_beat <= '0;
      else if (w_cd_hs[g]) r_beat <= snp_cd_last_i[g] ? '0 : r_beat + 1'b1;
    end

    a_last_on_final_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_cd_hs[g] |-> (snp_cd_last_i[g] == (r_beat == BeatW'(CdBeats - 1))));
  end

  a_cr_inside_mask: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_cr_hs & ~r_mask) == '0);
`endif

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Bench for ccu_snoop_fanout: directed scenarios then random transactions, each checked
// cycle by cycle against a transaction-level model of the snoopers and the merge rules.
module tb_ccu_snoop_fanout;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            ac_valid_i, ac_ready_o;
  logic [AW-1:0]   ac_addr_i;
  logic [3:0]      ac_snoop_i;
  logic [2:0]      ac_prot_i;
  logic [N-1:0]    domain_mask_i;
  logic            cr_valid_o, cr_ready_i;
  logic [4:0]      cr_resp_o;
  logic            cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0]   cd_data_o;
  logic [N-1:0]    snp_ac_valid_o, snp_ac_ready_i;
  logic [AW-1:0]   snp_ac_addr_o;
  logic [3:0]      snp_ac_snoop_o;
  logic [2:0]      snp_ac_prot_o;
  logic [N-1:0]    snp_cr_valid_i, snp_cr_ready_o;
  logic [5*N-1:0]  snp_cr_resp_i;
  logic [N-1:0]    snp_cd_valid_i, snp_cd_ready_o, snp_cd_last_i;
  logic [DW*N-1:0] snp_cd_data_i;

  int n_assert = 0;
  int n_fail   = 0;
  int txn_id   = 0;
  int g_ac_dly [N];
  int g_cr_dly [N];

  always #5 clk_i = ~clk_i;

  ccu_snoop_fanout #(.NumSnoopers(N), .AddrWidth(AW), .DataWidth(DW), .CdBeats(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .domain_mask_i(domain_mask_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i), .snp_ac_addr_o(snp_ac_addr_o),
    .snp_ac_snoop_o(snp_ac_snoop_o), .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o), .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data_i), .snp_cd_last_i(snp_cd_last_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn_id, got, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input int t, input int s, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(t) << 16) | (64'(s) << 8) | 64'(32'hA0 + b);
  endfunction

  // Merge rules: OR of shared/unique/DT, then a three-tier priority search for the data source.
  task automatic ref_merge(input logic [3:0] m, input logic [19:0] r,
                           output logic [4:0] resp, output int sel, output logic [3:0] dt);
    logic [4:0] c [N];
    logic sh, wu;
    sh = 1'b0; wu = 1'b0; dt = '0; sel = -1;
    for (int i = 0; i < N; i++) begin
      c[i]  = m[i] ? r[5*i +: 5] : 5'b0;
      dt[i] = c[i][0];
      sh    = sh | c[i][3];
      wu    = wu | c[i][4];
    end
    for (int i = 0; i < N; i++) if (sel < 0 && c[i][0] && c[i][2] && !c[i][1]) sel = i;
    for (int i = 0; i < N; i++) if (sel < 0 && c[i][0] && !c[i][1]) sel = i;
    for (int i = 0; i < N; i++) if (sel < 0 && c[i][0]) sel = i;
    if (sel >= 0) resp = {wu, sh, c[sel][2], c[sel][1], 1'b1};
    else          resp = {wu, sh, 3'b000};
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ac_ready"}, ac_ready_o, 1);
    chk({tag, "_cr"}, {cr_valid_o, cr_resp_o}, 0);
    chk({tag, "_cd"}, {cd_valid_o, cd_last_o}, 0);
    chk({tag, "_cd_data"}, cd_data_o, 0);
    chk({tag, "_snp_rdy_vld"}, {snp_ac_valid_o, snp_cr_ready_o, snp_cd_ready_o}, 0);
    chk({tag, "_snp_payload"}, snp_ac_addr_o | 64'({snp_ac_snoop_o, snp_ac_prot_o}), 0);
  endtask

  task automatic clear_inputs();
    ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0; domain_mask_i = '0;
    cr_ready_i = 0; cd_ready_i = 0; snp_ac_ready_i = '0; snp_cr_valid_i = '0;
    snp_cr_resp_i = '0; snp_cd_valid_i = '0; snp_cd_data_i = '0; snp_cd_last_i = '0;
  endtask

  task automatic set_dly(input int a, input int c);
    for (int i = 0; i < N; i++) begin
      g_ac_dly[i] = a;
      g_cr_dly[i] = c;
    end
  endtask

  // One full transaction; rst_at >= 0 pulses reset once that many beats have been forwarded.
  task automatic run_txn(input logic [3:0] mask, input logic [19:0] resps, input logic [63:0] addr,
                         input bit tog, input int rst_at);
    logic [4:0] exp_resp;
    int         sel, end_k, fwd;
    logic [3:0] dt, ac_hsv, cr_accv, cd_drv, cd_fin, exp_acv, exp_crr, exp_cdr;
    int         beat [N];
    bit         cr_up, done, exp_cdv, exp_crv;
    logic [3:0] snp;
    logic [2:0] prot;
    txn_id++;
    ref_merge(mask, resps, exp_resp, sel, dt);
    snp = 4'($urandom); prot = 3'($urandom);
    ac_hsv = '0; cr_accv = '0; cd_drv = '0; cd_fin = '0;
    for (int i = 0; i < N; i++) beat[i] = 0;
    end_k = -1; fwd = 0; cr_up = 0; done = 0;
    @(negedge clk_i);
    snp_cr_valid_i = '0; snp_cd_valid_i = '0;
    ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = snp; ac_prot_i = prot; domain_mask_i = mask;
    #1 chk("ac_ready_idle", ac_ready_o, 1);
    @(negedge clk_i);
    ac_valid_i = 0; ac_addr_i = {$urandom, $urandom}; domain_mask_i = 4'($urandom);
    for (int k = 1; k <= 400 && !done; k++) begin
      for (int i = 0; i < N; i++) begin
        snp_ac_ready_i[i] = !mask[i] || (k > g_ac_dly[i]);
        snp_cr_valid_i[i] = mask[i] && !cr_accv[i] && (k >= g_ac_dly[i] + 1 + g_cr_dly[i]);
        snp_cr_resp_i[5*i +: 5] = snp_cr_valid_i[i] ? resps[5*i +: 5] : 5'($urandom);
        if (dt[i] && cr_accv[i] && !cd_fin[i] && !cd_drv[i]) cd_drv[i] = ($urandom_range(3) != 0);
        snp_cd_valid_i[i] = cd_drv[i];
        snp_cd_data_i[DW*i +: DW] = mkdata(txn_id, i, beat[i]);
        snp_cd_last_i[i] = cd_drv[i] && (beat[i] == 3);
      end
      cd_ready_i = tog ? (k % 2 == 1) : ($urandom_range(3) != 0);
      cr_ready_i = ($urandom_range(1) == 1);
      if (rst_at >= 0 && fwd == rst_at) begin
        clear_inputs();
        rst_ni = 0;
        #1 chk_reset_outs("mid_rst");
        @(negedge clk_i);
        rst_ni = 1;
        return;
      end
      #1;
      exp_acv = (mask != 0 && cr_accv != mask) ? (mask & ~ac_hsv) : 4'b0;
      exp_crr = (mask != 0 && cr_accv != mask) ? (mask & ~cr_accv) : 4'b0;
      for (int i = 0; i < N; i++)
        exp_cdr[i] = cr_up && dt[i] && !cd_fin[i] && ((i == sel) ? cd_ready_i : 1'b1);
      exp_cdv = (sel >= 0) ? (cr_up && cd_drv[sel] && !cd_fin[sel]) : 1'b0;
      exp_crv = !cr_up && (cr_accv == mask);
      chk("snp_ac_valid", snp_ac_valid_o, exp_acv);
      chk("snp_cr_ready", snp_cr_ready_o, exp_crr);
      chk("snp_cd_ready", snp_cd_ready_o, exp_cdr);
      chk("cd_valid", cd_valid_o, exp_cdv);
      chk("ac_ready", ac_ready_o, k == end_k);
      chk("cr_valid", cr_valid_o, exp_crv);
      if (k == end_k) done = 1;
      if (exp_acv != 0) chk("ac_payload", {snp_ac_addr_o ^ addr} | 64'({snp_ac_snoop_o ^ snp, snp_ac_prot_o ^ prot}), 0);
      if (exp_crv) chk("cr_resp", cr_resp_o, exp_resp);
      if (exp_cdv) begin
        chk("cd_data", cd_data_o, mkdata(txn_id, sel, beat[sel]));
        chk("cd_last", cd_last_o, beat[sel] == 3);
      end
      ac_hsv  = ac_hsv | (exp_acv & snp_ac_ready_i);
      cr_accv = cr_accv | (exp_crr & snp_cr_valid_i);
      for (int i = 0; i < N; i++) begin
        if (exp_cdr[i] && snp_cd_valid_i[i]) begin
          if (i == sel) fwd++;
          beat[i]++;
          if (beat[i] == 4) cd_fin[i] = 1'b1;
          cd_drv[i] = !cd_fin[i] && ($urandom_range(3) != 0);
          if ((cd_fin & dt) == dt) end_k = k + 1;
        end
      end
      if (exp_crv && cr_ready_i) begin
        cr_up = 1;
        if (dt == 0) end_k = k + 1;
      end
      @(negedge clk_i);
    end
    chk("txn_complete", done, 1);
  endtask

  initial begin
    clear_inputs();
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    chk_reset_outs("por");
    rst_ni = 1;

    set_dly(0, 0);
    run_txn(4'b0000, 20'h0, 64'h1000, 0, -1);
    set_dly(1, 0);
    run_txn(4'b0010, {5'b0, 5'b0, 5'b01001, 5'b0}, 64'h2000, 0, -1);
    set_dly(0, 1);
    run_txn(4'b1110, {5'b01000, 5'b00101, 5'b00001, 5'b0}, 64'h3000, 0, -1);
    set_dly(0, 0);
    run_txn(4'b0011, {5'b0, 5'b0, 5'b00001, 5'b00011}, 64'h4000, 1, -1);

    g_ac_dly = '{0, 3, 7, 0};
    g_cr_dly = '{5, 0, 0, 0};
    run_txn(4'b0111, {5'b0, 5'b00000, 5'b01001, 5'b00101}, 64'h5000, 1, -1);

    set_dly(0, 0);
    run_txn(4'b0011, {5'b0, 5'b0, 5'b00001, 5'b00101}, 64'h6000, 0, 2);
    run_txn(4'b0010, {5'b0, 5'b0, 5'b01001, 5'b0}, 64'h7000, 0, -1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        g_ac_dly[i] = $urandom_range(7);
        g_cr_dly[i] = $urandom_range(4);
      end
      run_txn(4'($urandom_range(15)), 20'($urandom), {$urandom, $urandom},
              1'($urandom_range(1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
